// File: rtl/vid_stream_pkg.sv
// -----------------------------------------------------------------------------
// vid_stream_pkg
//   Shared types for the synthetic video stream generator: FSM state encoding,
//   test-pattern selector, default counter width and the latched frame
//   configuration record.
// -----------------------------------------------------------------------------
package vid_stream_pkg;

  // Default width of geometry/blanking counters and configuration fields.
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LSTART = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } state_e;

  // Pixel source selector: x ramp, y ramp, x^y checker, frame counter.
  typedef enum logic [1:0] {
    PAT_X   = 2'd0,
    PAT_Y   = 2'd1,
    PAT_XOR = 2'd2,
    PAT_FRM = 2'd3
  } pattern_e;

  // Frame configuration, captured as a whole at each latch point so that
  // mid-frame changes on the inputs never tear a frame.
  typedef struct packed {
    logic [CNT_WIDTH_DEF-1:0] width;
    logic [CNT_WIDTH_DEF-1:0] height;
    logic [3:0]               de_period;
    logic [CNT_WIDTH_DEF-1:0] hblank;
    logic [CNT_WIDTH_DEF-1:0] vblank;
    pattern_e                 pattern;
  } vid_cfg_t;

endpackage : vid_stream_pkg

// File: rtl/vid_stream_if.sv
// -----------------------------------------------------------------------------
// vid_stream_if
//   Video stream bundle between a pixel source and a sink (e.g. scaler_h).
//   Signals:
//     do_o         pixel data, valid when de_o=1
//     de_o         pixel valid
//     hs_o         one-cycle line-start pulse
//     vs_o         0 during active frame, 1 during vertical blank / idle
//     frame_done_o one-cycle pulse on the last vertical-blank cycle
//   Modports: master (source drives), slave (sink observes).
// -----------------------------------------------------------------------------
interface vid_stream_if #(
  parameter int PIXEL_WIDTH = 8
);

  logic [PIXEL_WIDTH-1:0] do_o;
  logic                   de_o;
  logic                   hs_o;
  logic                   vs_o;
  logic                   frame_done_o;

  modport master (
    output do_o,
    output de_o,
    output hs_o,
    output vs_o,
    output frame_done_o
  );

  modport slave (
    input do_o,
    input de_o,
    input hs_o,
    input vs_o,
    input frame_done_o
  );

endinterface : vid_stream_if

// File: rtl/vid_stream_pix.sv
// -----------------------------------------------------------------------------
// vid_stream_pix
//   Combinational test-pattern mux. Selects the low PIXEL_WIDTH bits of the
//   pixel column, line, column^line or the frame counter. The result is
//   registered by the instantiating module.
//   Ports:
//     x_i       pixel column within the line
//     y_i       line within the frame
//     frame_i   frame counter
//     pattern_i pattern selector
//     pix_o     pixel value
// -----------------------------------------------------------------------------
module vid_stream_pix
  import vid_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic [CNT_WIDTH-1:0]   x_i,
  input  logic [CNT_WIDTH-1:0]   y_i,
  input  logic [PIXEL_WIDTH-1:0] frame_i,
  input  pattern_e               pattern_i,
  output logic [PIXEL_WIDTH-1:0] pix_o
);

  logic [CNT_WIDTH-1:0] xy_xor;

  assign xy_xor = x_i ^ y_i;

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    pix_o = '0;
    case (pattern_i)
      PAT_X:   pix_o = PIXEL_WIDTH'(x_i);
      PAT_Y:   pix_o = PIXEL_WIDTH'(y_i);
      PAT_XOR: pix_o = PIXEL_WIDTH'(xy_xor);
      PAT_FRM: pix_o = frame_i;
      default: pix_o = '0;
    endcase
  end

endmodule : vid_stream_pix

// File: rtl/vid_stream_gen.sv
// -----------------------------------------------------------------------------
// vid_stream_gen
//   Synthetic video source with programmable geometry, per-pixel DE gaps,
//   horizontal/vertical blanking and a selectable test pattern.
//   Frame shape, per line: LSTART (1 cycle, hs), ACTIVE (width slots of
//   de_period+1 cycles, de on the last cycle of each slot), HBLANK; after the
//   last line, VBLANK. Zero blanking lengths behave as one cycle.
//   Ports:
//     clk, rst_n    clock, synchronous active-low reset
//     en_i          run request, sampled in IDLE and on the last VBLANK cycle
//     width_i       active pixels per line
//     height_i      active lines per frame
//     de_period_i   idle cycles inserted before each pixel
//     hblank_i      cycles between lines
//     vblank_i      cycles after the last line
//     pattern_i     0=x ramp, 1=y ramp, 2=x^y, 3=frame counter
//     vid           stream outputs (do_o/de_o/hs_o/vs_o/frame_done_o)
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module vid_stream_gen
  import vid_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] width_i,
  input  logic [CNT_WIDTH-1:0] height_i,
  input  logic [3:0]           de_period_i,
  input  logic [CNT_WIDTH-1:0] hblank_i,
  input  logic [CNT_WIDTH-1:0] vblank_i,
  input  logic [1:0]           pattern_i,
  vid_stream_if.master         vid
);

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  vid_cfg_t               cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0]   x_q, x_d;
  logic [CNT_WIDTH-1:0]   y_q, y_d;
  logic [3:0]             slot_q, slot_d;     // cycle index inside a pixel slot
  logic [CNT_WIDTH-1:0]   blank_q, blank_d;   // cycle index inside a blank
  logic [PIXEL_WIDTH-1:0] frame_q, frame_d;

  // Registered outputs
  logic [PIXEL_WIDTH-1:0] do_q, do_d;
  logic                   de_q, de_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   fd_q, fd_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  vid_cfg_t             new_cfg;
  logic                 start_ok;
  logic [CNT_WIDTH:0]   blank_inc_q;
  logic [CNT_WIDTH:0]   blank_inc_d;
  logic                 hblank_last;
  logic                 vblank_last;
  logic                 vblank_last_d;
  logic                 slot_last;
  logic                 line_last_pix;
  logic                 frame_last_line;
  logic [PIXEL_WIDTH-1:0] pix;

  // A frame may only start with a non-degenerate geometry; a zero width or
  // height would leave ACTIVE/HBLANK without a terminal count.
  assign start_ok = en_i && (width_i != '0) && (height_i != '0);

  always_comb begin
    new_cfg           = '0;
    new_cfg.width     = width_i;
    new_cfg.height    = height_i;
    new_cfg.de_period = de_period_i;
    new_cfg.hblank    = hblank_i;
    new_cfg.vblank    = vblank_i;
    new_cfg.pattern   = pattern_e'(pattern_i);
  end

  // "blank index + 1 >= length" ends the blank; a zero length therefore ends
  // on the first cycle, giving the one-cycle minimum without a separate mux.
  assign blank_inc_q   = {1'b0, blank_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign blank_inc_d   = {1'b0, blank_d} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign hblank_last   = blank_inc_q >= {1'b0, cfg_q.hblank};
  assign vblank_last   = blank_inc_q >= {1'b0, cfg_q.vblank};
  assign vblank_last_d = blank_inc_d >= {1'b0, cfg_d.vblank};

  assign slot_last       = slot_q == cfg_q.de_period;
  assign line_last_pix   = x_q == cfg_q.width - CNT_WIDTH'(1);
  assign frame_last_line = y_q == cfg_q.height - CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    x_d     = x_q;
    y_d     = y_q;
    slot_d  = slot_q;
    blank_d = blank_q;
    frame_d = frame_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          cfg_d   = new_cfg;
          x_d     = '0;
          y_d     = '0;
          slot_d  = '0;
          state_d = ST_LSTART;
        end
      end

      ST_LSTART: begin
        slot_d  = '0;
        state_d = ST_ACTIVE;
      end

      ST_ACTIVE: begin
        if (slot_last) begin
          slot_d = '0;
          if (line_last_pix) begin
            blank_d = '0;
            state_d = ST_HBLANK;
          end else begin
            x_d = x_q + CNT_WIDTH'(1);
          end
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end

      ST_HBLANK: begin
        if (hblank_last) begin
          blank_d = '0;
          if (frame_last_line) begin
            state_d = ST_VBLANK;
          end else begin
            y_d     = y_q + CNT_WIDTH'(1);
            x_d     = '0;
            state_d = ST_LSTART;
          end
        end else begin
          blank_d = blank_q + CNT_WIDTH'(1);
        end
      end

      ST_VBLANK: begin
        if (vblank_last) begin
          blank_d = '0;
          frame_d = frame_q + PIXEL_WIDTH'(1);
          // Back-to-back frame: the config is re-latched here so the new
          // frame starts on the very next cycle with no IDLE gap.
          if (start_ok) begin
            cfg_d   = new_cfg;
            x_d     = '0;
            y_d     = '0;
            slot_d  = '0;
            state_d = ST_LSTART;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          blank_d = blank_q + CNT_WIDTH'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs are decoded from the next state and registered, so
  // each flop output describes the cycle the FSM is currently in.
  // ---------------------------------------------------------------------------
  vid_stream_pix #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_pix (
    .x_i       (x_d),
    .y_i       (y_d),
    .frame_i   (frame_d),
    .pattern_i (cfg_d.pattern),
    .pix_o     (pix)
  );

  always_comb begin
    de_d = (state_d == ST_ACTIVE) && (slot_d == cfg_d.de_period);
    hs_d = (state_d == ST_LSTART);
    vs_d = !(state_d inside {ST_LSTART, ST_ACTIVE, ST_HBLANK});
    fd_d = (state_d == ST_VBLANK) && vblank_last_d;
    do_d = de_d ? pix : '0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: there is no memory here; every flop, configuration included, has a
  // defined reset value so a mid-frame reset leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      slot_q  <= '0;
      blank_q <= '0;
      frame_q <= '0;
      do_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      slot_q  <= slot_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
      do_q    <= do_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fd_q    <= fd_d;
    end
  end

  assign vid.do_o         = do_q;
  assign vid.de_o         = de_q;
  assign vid.hs_o         = hs_q;
  assign vid.vs_o         = vs_q;
  assign vid.frame_done_o = fd_q;

endmodule : vid_stream_gen

// File: tb/tb_vid_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_vid_stream_gen
//   Self-checking bench for vid_stream_gen. A reference model expands each
//   started frame into its expected per-cycle output sequence with nested
//   loops over lines, pixels and slots; every cycle the DUT outputs are
//   compared with the next expected entry (or the idle pattern). Each frame's
//   measured length is also compared with the closed-form frame length.
// -----------------------------------------------------------------------------
module tb_vid_stream_gen;

  localparam int PW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i;
  logic [CW-1:0] width_i;
  logic [CW-1:0] height_i;
  logic [3:0]    de_period_i;
  logic [CW-1:0] hblank_i;
  logic [CW-1:0] vblank_i;
  logic [1:0]    pattern_i;

  vid_stream_if #(.PIXEL_WIDTH(PW)) vid ();

  vid_stream_gen #(
    .PIXEL_WIDTH (PW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .width_i     (width_i),
    .height_i    (height_i),
    .de_period_i (de_period_i),
    .hblank_i    (hblank_i),
    .vblank_i    (vblank_i),
    .pattern_i   (pattern_i),
    .vid         (vid)
  );

  always #5 clk = ~clk;

  // Expected cycle: {de, hs, vs, frame_done, do[7:0]}
  typedef logic [11:0] exp_t;

  exp_t exp_q[$];
  int   len_q[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  int   frames_done = 0;
  bit   in_frame  = 0;
  int   meas      = 0;

  function automatic exp_t mk(bit de, bit hs, bit vs, bit fd, logic [7:0] d);
    return {de, hs, vs, fd, d};
  endfunction

  localparam exp_t IDLE_EXP = 12'b0010_0000_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pixval(int pat, int x, int y, int fr);
    int v;
    case (pat)
      0:       v = x;
      1:       v = y;
      2:       v = x ^ y;
      default: v = fr;
    endcase
    return 8'(v);
  endfunction

  // Expand one frame from the currently driven configuration.
  task automatic push_frame();
    int w   = int'(width_i);
    int h   = int'(height_i);
    int dp  = int'(de_period_i);
    int hb  = (hblank_i == 0) ? 1 : int'(hblank_i);
    int vb  = (vblank_i == 0) ? 1 : int'(vblank_i);
    int pat = int'(pattern_i);
    int fr  = frames_done % 256;
    for (int y = 0; y < h; y++) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
      for (int x = 0; x < w; x++)
        for (int s = 0; s <= dp; s++)
          if (s == dp) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, pixval(pat, x, y, fr)));
          else         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
      for (int b = 0; b < hb; b++)
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    end
    for (int b = 0; b < vb; b++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, (b == vb - 1), 8'h00));
    len_q.push_back(h * (1 + w * (dp + 1) + hb) + vb);
  endtask

  // One clock cycle: inputs have been driven just after the rising edge.
  task automatic tick();
    exp_t e;
    exp_t got;
    int   exp_len;
    @(negedge clk);
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_EXP;
    got = {vid.de_o, vid.hs_o, vid.vs_o, vid.frame_done_o, vid.do_o};
    check($sformatf("cyc%0d", cyc), 32'(got), 32'(e));

    // Frame length measured on DUT outputs: first hs to frame_done inclusive.
    if (vid.hs_o && !in_frame) begin
      in_frame = 1;
      meas     = 0;
    end
    if (in_frame) meas++;
    if (vid.frame_done_o && in_frame) begin
      exp_len  = (len_q.size() > 0) ? len_q.pop_front() : -1;
      check($sformatf("frame_len@%0d", cyc), 32'(meas), 32'(exp_len));
      in_frame = 0;
    end

    if (e[8]) frames_done++;

    if (!rst_n) begin
      exp_q.delete();
      len_q.delete();
      frames_done = 0;
      in_frame    = 0;
    end else if (exp_q.size() == 0 && en_i && width_i != 0 && height_i != 0) begin
      push_frame();
    end

    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int w, input int h, input int dp, input int hb,
                         input int vb, input int pat);
    width_i     = 16'(w);
    height_i    = 16'(h);
    de_period_i = 4'(dp);
    hblank_i    = 16'(hb);
    vblank_i    = 16'(vb);
    pattern_i   = 2'(pat);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    en_i = 1'b0;
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) tick();
    run(2);
  endtask

  initial begin
    rst_n = 1'b0;
    en_i  = 1'b0;
    set_cfg(4, 2, 0, 3, 2, 0);
    @(posedge clk);
    #1;
    run(2);                             // reset state
    rst_n = 1'b1;
    run(3);

    // 1: contiguous DE, x ramp, 18-cycle frame
    set_cfg(4, 2, 0, 3, 2, 0);
    en_i = 1'b1; tick(); en_i = 1'b0;
    run(24);

    // 2: de_period=3, 42-cycle frame
    set_cfg(4, 2, 3, 3, 2, 0);
    en_i = 1'b1; tick(); en_i = 1'b0;
    run(48);

    // 3: x^y checker on 4x4
    set_cfg(4, 4, 0, 1, 1, 2);
    en_i = 1'b1; tick(); en_i = 1'b0;
    run(30);

    // 4: back-to-back frames, frame counter pattern, width changed mid-frame
    set_cfg(4, 2, 0, 2, 1, 3);
    en_i = 1'b1;
    run(5);
    width_i = 16'd6;
    run(50);
    drain();

    // 5: reset mid-ACTIVE, then restart
    set_cfg(8, 3, 1, 2, 2, 0);
    en_i = 1'b1;
    run(7);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    run(10);
    drain();

    // 6: zero width stays idle; zero blanking behaves as one cycle
    set_cfg(0, 3, 0, 2, 2, 0);
    en_i = 1'b1;
    run(10);
    set_cfg(3, 2, 0, 0, 0, 1);
    tick();
    en_i = 1'b0;
    drain();

    // Randomized: config churn, en toggling, rare resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_cfg($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      en_i  = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_vid_stream_gen

// File: doc/vid_stream_gen.md
Name: vid_stream_gen

Overview:
- Source-side counterpart of the horizontal/vertical scaler input port.
- Generates a synthetic video stream (do_o/de_o/hs_o/vs_o) with programmable frame geometry, per-pixel DE gaps, blanking and test pattern.
- Feeds scaler_h directly in hardware bring-up and replaces bench-side stimulus loops.
- All outputs are registered; one clock domain.

Parameters:
PIXEL_WIDTH, 8, bits per output pixel
CNT_WIDTH, 16, width of geometry/blanking counters and config inputs

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en_i  in  1  run request; sampled only in IDLE and at end of frame
width_i  in  CNT_WIDTH  active pixels per line
height_i  in  CNT_WIDTH  active lines per frame
de_period_i  in  4  idle cycles inserted before each pixel (0 = contiguous)
hblank_i  in  CNT_WIDTH  cycles between lines (0 treated as 1)
vblank_i  in  CNT_WIDTH  cycles after last line (0 treated as 1)
pattern_i  in  2  0=x ramp, 1=y ramp, 2=x^y, 3=frame counter
do_o  out  PIXEL_WIDTH  pixel data, valid when de_o=1
de_o  out  1  pixel valid
hs_o  out  1  one-cycle line-start pulse
vs_o  out  1  0 during active frame, 1 during vertical blank/idle
frame_done_o  out  1  one-cycle pulse on last VBLANK cycle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: do_o=0, de_o=0, hs_o=0, vs_o=1, frame_done_o=0, state=IDLE, x=y=0, frame counter=0. rst_n low mid-frame: these values appear on the next edge; the partial frame is abandoned.
- FSM states: IDLE, LSTART, ACTIVE, HBLANK, VBLANK.
- IDLE: en_i=1 and width_i!=0 and height_i!=0 -> latch all config inputs -> LSTART. Otherwise stay in IDLE.
- LSTART (1 cycle): hs_o=1, vs_o=0, de_o=0 -> ACTIVE.
- ACTIVE: width slots of (de_period+1) cycles each.
  - de_o=1 only in the last cycle of each slot; do_o is valid in that same cycle.
  - x increments after each DE cycle.
  - After pixel width-1 -> HBLANK.
- HBLANK: max(hblank,1) cycles, vs_o=0. Then y<height-1 -> y++, x=0, LSTART; else -> VBLANK.
- VBLANK: max(vblank,1) cycles, vs_o=1. The last cycle pulses frame_done_o and increments the frame counter (wraps at 2^PIXEL_WIDTH).
  - en_i=1 at that cycle: re-latch config, y=0 -> LSTART (back-to-back frame).
  - Else -> IDLE.
- Config inputs changing mid-frame have no effect until the next latch point. en_i deassert mid-frame: the current frame completes.
- Pixel value: low PIXEL_WIDTH bits of x, y, x^y, or the frame counter, per the latched pattern. Truncation wraps silently.
- Frame length in cycles: height*(1+width*(de_period+1)+max(hblank,1)) + max(vblank,1).
- hs_o and de_o never assert in the same cycle. de_o is never 1 outside ACTIVE.

Decomposition:
- Package vid_stream_pkg: state enum, pattern enum (PAT_X, PAT_Y, PAT_XOR, PAT_FRM), CNT_WIDTH default, config struct (width, height, de_period, hblank, vblank, pattern).
- One sub-module vid_stream_pix: combinational pattern mux from x, y, frame counter and pattern -> pixel. Registered in the top.
- Everything else (FSM, x/y/slot/blank counters) lives in vid_stream_gen.

Test Plan:
1. width=4, height=2, de_period=0, hblank=3, vblank=2, pattern=0; en_i pulsed 1 cycle -> hs_o one cycle after en, de_o 4 contiguous cycles with do_o=0,1,2,3, 3 blank cycles, repeat for line 1, vs_o=1 for 2 cycles, frame_done_o once, 18 cycles total, then IDLE.
2. Same geometry, de_period=3 -> de_o high every 4th cycle, ACTIVE lasts 16 cycles per line, frame = 2*(1+16+3)+2 = 42 cycles.
3. width=4, height=4, pattern=2 -> line 1 do_o=1,0,3,2; line 3 do_o=3,2,1,0.
4. en_i held high with pattern=3; width_i changed mid-frame -> frames back-to-back with no IDLE cycle; do_o=0 in frame 0, 1 in frame 1; new width takes effect only in the following frame.
5. rst_n low for 1 cycle mid-ACTIVE -> next cycle de_o=0, hs_o=0, vs_o=1; restart yields do_o starting from x=0, y=0.
6. width_i=0 with en_i=1 -> remains IDLE, no hs_o/de_o. hblank_i=0 and vblank_i=0 -> each behaves as 1 blank cycle.
